// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/subtract engine. Operands are processed DIGIT
// bits per clock, LSB first, through a DIGIT-wide ripple of full adder or full
// subtractor cells. One operation takes N = WIDTH/DIGIT RUN cycles.
//
// Handshake (valid/ready): an operation is accepted on a rising edge where
// start=1 and ready=1. a, b, sub and cin are captured on that edge and may
// change freely afterwards. ready stays 0 for the N cycles of the operation.
// done then pulses for one cycle, and result/cout/ovf update at the same time.
// A start seen while ready=0 is ignored.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     operation request
//   a, b      WIDTH-bit operands (A+B+cin or A-B-cin)
//   sub       0 = add, 1 = subtract (cin then acts as borrow-in)
//   cin       carry-in or borrow-in
//   ready     1 while idle and able to accept
//   done      one-cycle completion pulse
//   result    sum or difference, modulo 2^WIDTH
//   cout      carry-out or borrow-out from the MSB
//   ovf       two's-complement signed overflow
//   state_dbg current FSM state (0 = IDLE, 1 = RUN)
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             state_dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  // Working registers. a_sh/b_sh shift right so the current digit always sits
  // in the low DIGIT bits. acc fills from the top, so after N digits the first
  // digit processed has reached bit 0.
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic             sub_r;
  logic             c_r;
  logic [CW-1:0]    cnt;

  logic             last;
  logic [DIGIT-1:0] digit_out;
  logic             c_run;
  logic             c_msb_in;
  logic [WIDTH-1:0] acc_next;

  assign last      = (cnt == CW'(N - 1));
  assign ready     = (state == IDLE);
  assign state_dbg = state;

  // Ripple across one digit. The carry or borrow of each bit feeds the next
  // bit in the same cycle. c_msb_in holds the carry into the top bit of the
  // digit. On the last digit that is the carry into the word MSB, which the
  // overflow rule needs.
  always_comb begin
    digit_out = '0;
    c_run     = c_r;
    c_msb_in  = c_r;
    for (int j = 0; j < DIGIT; j++) begin
      digit_out[j] = a_sh[j] ^ b_sh[j] ^ c_run;
      if (j == DIGIT - 1) c_msb_in = c_run;
      if (sub_r) c_run = (~a_sh[j] & b_sh[j]) | (~(a_sh[j] ^ b_sh[j]) & c_run);
      else       c_run = (a_sh[j] & b_sh[j]) | (c_run & (a_sh[j] ^ b_sh[j]));
    end
  end

  assign acc_next = (acc >> DIGIT) | (WIDTH'(digit_out) << (WIDTH - DIGIT));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      sub_r  <= 1'b0;
      c_r    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            sub_r <= sub;
            c_r   <= cin;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          c_r  <= c_run;
          acc  <= acc_next;
          if (last) begin
            cnt    <= '0;
            result <= acc_next;
            cout   <= c_run;
            ovf    <= c_msb_in ^ c_run;
            done   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared operand inputs; one start per instance.
  logic [7:0] a = '0, b = '0;
  logic       sub = 1'b0, cin = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] ready_v, done_v, cout_v, ovf_v, dbg_v;
  logic [7:0] r0, r2;
  logic [3:0] r1;
  logic [7:0] res_w [3];

  // u0: WIDTH=8 DIGIT=1, u1: WIDTH=4 DIGIT=2, u2: WIDTH=8 DIGIT=4
  serial_addsub #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .sub(sub), .cin(cin),
    .ready(ready_v[0]), .done(done_v[0]), .result(r0), .cout(cout_v[0]),
    .ovf(ovf_v[0]), .state_dbg(dbg_v[0]));
  serial_addsub #(.WIDTH(4), .DIGIT(2)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a[3:0]), .b(b[3:0]), .sub(sub), .cin(cin),
    .ready(ready_v[1]), .done(done_v[1]), .result(r1), .cout(cout_v[1]),
    .ovf(ovf_v[1]), .state_dbg(dbg_v[1]));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .sub(sub), .cin(cin),
    .ready(ready_v[2]), .done(done_v[2]), .result(r2), .cout(cout_v[2]),
    .ovf(ovf_v[2]), .state_dbg(dbg_v[2]));

  assign res_w[0] = r0;
  assign res_w[1] = {4'b0000, r1};
  assign res_w[2] = r2;

  int nbits [3] = '{8, 4, 8};
  int ncyc  [3] = '{8, 2, 2};

  int tests_run = 0;
  int failed    = 0;

  logic [9:0] exp_q [$];
  int         due_q [$];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  // Returns {ovf, cout, result}.
  function automatic logic [9:0] model(input int w, input logic [7:0] ai, input logic [7:0] bi,
                                       input logic si, input logic ci);
    int m, ua, ub, sa, sb, r, sr;
    logic co, ov;
    m  = (1 << w) - 1;
    ua = int'(ai) & m;
    ub = int'(bi) & m;
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    if (si) begin
      r  = ua - ub - int'(ci);
      sr = sa - sb - int'(ci);
      co = (r < 0);
    end else begin
      r  = ua + ub + int'(ci);
      sr = sa + sb + int'(ci);
      co = (r > m);
    end
    ov = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
    return {ov, co, 8'(r & m)};
  endfunction

  // ---------------- driver ----------------
  // One operation on instance s. With noise set, start is pulsed on RUN
  // cycles 2 and 5 while the operand inputs carry other values.
  task automatic run_op(input int s, input logic [7:0] ai, input logic [7:0] bi,
                        input logic si, input logic ci, input bit noise);
    logic [9:0] e;
    logic [7:0] held;
    int cyc;
    e = model(nbits[s], ai, bi, si, ci);
    @(negedge clk);
    check("ready_idle", 32'(ready_v[s]), 32'd1);
    held = res_w[s];
    a = ai; b = bi; sub = si; cin = ci;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    cyc = 0;
    while (!done_v[s] && cyc < 40) begin
      check("ready_busy", 32'(ready_v[s]), 32'd0);
      check("res_stable", 32'(res_w[s]), 32'(held));
      @(negedge clk);
      cyc++;
      if (noise) start_v[s] = (cyc == 2 || cyc == 5);
    end
    start_v[s] = 1'b0;
    check("latency", 32'(cyc), 32'(ncyc[s]));
    check("result", 32'(res_w[s]), 32'(e[7:0]));
    check("cout", 32'(cout_v[s]), 32'(e[8]));
    check("ovf", 32'(ovf_v[s]), 32'(e[9]));
    check("ready_done", 32'(ready_v[s]), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(done_v[s]), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, got, launched, seen_done, due;
    logic [7:0] held;
    logic [9:0] e;

    // reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_ready", 32'(ready_v[s]), 32'd1);
      check("rst_done", 32'(done_v[s]), 32'd0);
      check("rst_result", 32'(res_w[s]), 32'd0);
      check("rst_cout", 32'(cout_v[s]), 32'd0);
      check("rst_ovf", 32'(ovf_v[s]), 32'd0);
    end
    rst = 1'b0;

    // directed cases, WIDTH=8 DIGIT=1
    run_op(0, 8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
    check("t1_const", 32'(r0), 32'h7F);
    run_op(0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    check("t2_borrow", 32'(cout_v[0]), 32'd1);
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    check("t2_ovf_add", 32'(ovf_v[0]), 32'd1);
    run_op(0, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    check("t2_ovf_sub", 32'(r0), 32'h7F);
    run_op(0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    run_op(0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);

    // exhaustive WIDTH=4 DIGIT=2
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int m = 0; m < 4; m++)
          run_op(1, 8'(ai), 8'(bi), m[1], m[0], 1'b0);

    // random operations on both 8-bit instances
    for (int k = 0; k < 30; k++) begin
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      run_op(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    // start pulses during RUN are ignored
    run_op(0, 8'h12, 8'hC4, 1'b0, 1'b1, 1'b1);
    run_op(0, 8'h9A, 8'h3C, 1'b1, 1'b0, 1'b1);

    // reset in the 3rd RUN cycle aborts the operation
    run_op(0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h5A; b = 8'h33; sub = 1'b0; cin = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready_v[0]), 32'd1);
    check("abort_done", 32'(done_v[0]), 32'd0);
    check("abort_result", 32'(r0), 32'd0);
    check("abort_cout", 32'(cout_v[0]), 32'd0);
    check("abort_ovf", 32'(ovf_v[0]), 32'd0);
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);

    // back-to-back with start held high, WIDTH=8 DIGIT=4
    t = 0; got = 0; launched = 0;
    held = r2;
    while (got < 10 && t < 200) begin
      @(negedge clk);
      t++;
      if (done_v[2]) begin
        due = (due_q.size() > 0) ? due_q.pop_front() : -1;
        e   = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
        check("b2b_latency", 32'(t), 32'(due));
        check("b2b_result", 32'(r2), 32'(e[7:0]));
        check("b2b_cout", 32'(cout_v[2]), 32'(e[8]));
        check("b2b_ovf", 32'(ovf_v[2]), 32'(e[9]));
        held = r2;
        got++;
      end else begin
        check("b2b_stable", 32'(r2), 32'(held));
      end
      if (ready_v[2] && launched < 10) begin
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        start_v[2] = 1'b1;
        exp_q.push_back(model(8, a, b, sub, cin));
        due_q.push_back(t + 1 + ncyc[2]);
        launched++;
      end else if (ready_v[2]) begin
        start_v[2] = 1'b0;
      end
    end
    start_v[2] = 1'b0;
    check("b2b_count", 32'(got), 32'd10);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
